// File: rtl/gray_sync_pkg.sv
// Shared helpers and limits for the multi-channel Gray pointer synchroniser.
// Functions work on a 32-bit container; callers pass the pointer MSB index.
package gray_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int NCH_MAX    = 8;
    localparam int WORD_W     = 32;

    // b[msb] = g[msb]; b[i] = b[i+1] ^ g[i]; bits above msb stay 0
    function automatic logic [WORD_W-1:0] gray2bin(input logic [WORD_W-1:0] g,
                                                   input int ptr_sz);
        logic [WORD_W-1:0] b;
        b = '0;
        b[ptr_sz] = g[ptr_sz];
        for (int i = ptr_sz - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input logic [WORD_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_chan.sv
// One pointer channel: flop chain, hold register, registered Gray-to-binary,
// update pulse and sticky Gray-violation flag. GRAY_PTR_SYNC_STEP_EN adds step.
module gray_sync_chan
    import gray_sync_pkg::*;
#(
    parameter int PTR_SZ = 2,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PTR_SZ:0] gray_in,
    input  logic            err_clr,
    output logic [PTR_SZ:0] gray_sync,
    output logic [PTR_SZ:0] bin_sync,
    output logic            upd,
    output logic            err
`ifdef GRAY_PTR_SYNC_STEP_EN
    ,
    output logic [PTR_SZ:0] step
`endif
);

    localparam int PTR_W = PTR_SZ + 1;

    logic [PTR_SZ:0] stage_reg [STAGES];
    logic [PTR_SZ:0] prev_reg;
    logic [PTR_SZ:0] bin_reg;
    logic            upd_reg;
    logic            err_reg;

    logic [PTR_SZ:0] last;
    logic [PTR_SZ:0] diff;
    logic [PTR_SZ:0] bin_next;
    logic            changed;
    logic            multi_bit;

    always_comb begin
        last      = stage_reg[STAGES-1];
        diff      = last ^ prev_reg;
        bin_next  = PTR_W'(gray2bin(WORD_W'(last), PTR_SZ));
        changed   = |diff;
        multi_bit = popcount(WORD_W'(diff)) > 6'd1;
    end

    // prev_reg and bin_reg load from the same sample, so prev_reg is always
    // the Gray value the current binary output was derived from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
            prev_reg <= '0;
            bin_reg  <= '0;
            upd_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            stage_reg[0] <= gray_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            prev_reg <= last;
            bin_reg  <= bin_next;
            upd_reg  <= changed;
            err_reg  <= multi_bit | (err_reg & ~err_clr);
        end
    end

`ifdef GRAY_PTR_SYNC_STEP_EN
    logic [PTR_SZ:0] step_reg;

    // Modular difference gives the forward distance even across a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_reg <= '0;
        end else if (changed) begin
            step_reg <= bin_next - bin_reg;
        end
    end

    assign step = step_reg;
`endif

    assign gray_sync = last;
    assign bin_sync  = bin_reg;
    assign upd       = upd_reg;
    assign err       = err_reg;

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel Gray FIFO pointer synchroniser in the destination clock domain.
// Define GRAY_PTR_SYNC_STEP_EN to add the per-channel ptr_step output.
module gray_ptr_sync
    import gray_sync_pkg::*;
#(
    parameter int PTR_SZ = 2,
    parameter int STAGES = 2,
    parameter int NCH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*(PTR_SZ+1)-1:0] ptr_gray_in,
    input  logic [NCH-1:0]            err_clr,
    output logic [NCH*(PTR_SZ+1)-1:0] ptr_gray_sync,
    output logic [NCH*(PTR_SZ+1)-1:0] ptr_bin_sync,
    output logic [NCH-1:0]            ptr_upd,
    output logic [NCH-1:0]            gray_err
`ifdef GRAY_PTR_SYNC_STEP_EN
    ,
    output logic [NCH*(PTR_SZ+1)-1:0] ptr_step
`endif
);

    localparam int PTR_W = PTR_SZ + 1;

    generate
        if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
        end
        if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
            $error("gray_ptr_sync: NCH=%0d outside 1..%0d", NCH, NCH_MAX);
        end
        if (PTR_SZ < 0 || PTR_SZ >= WORD_W) begin : g_bad_ptr
            $error("gray_ptr_sync: PTR_SZ=%0d unsupported", PTR_SZ);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            gray_sync_chan #(
                .PTR_SZ (PTR_SZ),
                .STAGES (STAGES)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .gray_in   (ptr_gray_in[gi*PTR_W +: PTR_W]),
                .err_clr   (err_clr[gi]),
                .gray_sync (ptr_gray_sync[gi*PTR_W +: PTR_W]),
                .bin_sync  (ptr_bin_sync[gi*PTR_W +: PTR_W]),
                .upd       (ptr_upd[gi]),
                .err       (gray_err[gi])
`ifdef GRAY_PTR_SYNC_STEP_EN
                ,
                .step      (ptr_step[gi*PTR_W +: PTR_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench: stimulus pushes expected update records, a negedge monitor
// pops one per ptr_upd pulse. A second instance covers STAGES=4, NCH=3.
module tb_gray_ptr_sync;

    typedef struct packed {
        logic       ch;
        logic [2:0] gray;
        logic [2:0] bin;
        logic       err;
        logic [2:0] step;
    } exp_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic [5:0] in_a, gs_a, bs_a;
    logic [1:0] clr_a, upd_a, err_a;
    logic [8:0] in_b, gs_b, bs_b;
    logic [2:0] clr_b, upd_b, err_b;
`ifdef GRAY_PTR_SYNC_STEP_EN
    logic [5:0] step_a;
    logic [8:0] step_b;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    gray_ptr_sync #(.PTR_SZ(2), .STAGES(2), .NCH(2)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .ptr_gray_in   (in_a),
        .err_clr       (clr_a),
        .ptr_gray_sync (gs_a),
        .ptr_bin_sync  (bs_a),
        .ptr_upd       (upd_a),
        .gray_err      (err_a)
`ifdef GRAY_PTR_SYNC_STEP_EN
        ,
        .ptr_step      (step_a)
`endif
    );

    gray_ptr_sync #(.PTR_SZ(2), .STAGES(4), .NCH(3)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .ptr_gray_in   (in_b),
        .err_clr       (clr_b),
        .ptr_gray_sync (gs_b),
        .ptr_bin_sync  (bs_b),
        .ptr_upd       (upd_b),
        .gray_err      (err_b)
`ifdef GRAY_PTR_SYNC_STEP_EN
        ,
        .ptr_step      (step_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic ch, input logic [2:0] g, input logic [2:0] b,
                                input logic e, input logic [2:0] s);
        exp_t r;
        r.ch = ch; r.gray = g; r.bin = b; r.err = e; r.step = s;
        return r;
    endfunction

    // Monitor: one scoreboard entry per asserted ptr_upd bit, channel order 0..1.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_a) begin
                for (int c = 0; c < 2; c++) begin
                    if (upd_a[c]) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected: ch%0d upd with bin=%b, none expected", c, bs_a[c*3 +: 3]);
                        end else begin
                            exp_t e;
                            logic ok;
                            e  = sb_q.pop_front();
                            ok = (e.ch == c[0]) && (e.gray == gs_a[c*3 +: 3]) &&
                                 (e.bin == bs_a[c*3 +: 3]) && (e.err == err_a[c]);
`ifdef GRAY_PTR_SYNC_STEP_EN
                            ok = ok && (e.step == step_a[c*3 +: 3]);
`endif
                            if (!ok) begin
                                errors++;
                                $display("FAIL sb_upd: ch%0d gray=%b bin=%b err=%b expected ch%0d gray=%b bin=%b err=%b step=%0d",
                                         c, gs_a[c*3 +: 3], bs_a[c*3 +: 3], err_a[c], e.ch, e.gray, e.bin, e.err, e.step);
                            end else begin
                                $display("upd ch%0d gray=%b bin=%b err=%b", c, gs_a[c*3 +: 3], bs_a[c*3 +: 3], err_a[c]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] gseq [8];
        logic [2:0] bseq [8];
        gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        bseq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        rst_a = 1'b0; rst_b = 1'b0;
        in_a = 6'b101_101; clr_a = 2'b00;
        in_b = 9'd0;       clr_b = 3'b000;
        repeat (3) tick();
        chk("rst_gray", 32'(gs_a), 32'h0);
        chk("rst_bin",  32'(bs_a), 32'h0);
        chk("rst_upd",  32'(upd_a), 32'h0);
        chk("rst_err",  32'(err_a), 32'h0);

        // Release: 101 reaches gray out after 2 edges, binary 110 after 3
        rst_a = 1'b1;
        sb_q.push_back(mk(1'b0, 3'b101, 3'b110, 1'b1, 3'd6));
        sb_q.push_back(mk(1'b1, 3'b101, 3'b110, 1'b1, 3'd6));
        tick(); chk("lat_gray_e1", 32'(gs_a), 32'h0);
        tick(); chk("lat_gray_e2", 32'(gs_a), 32'(6'b101_101));
                chk("lat_bin_e2",  32'(bs_a), 32'h0);
        tick(); chk("lat_bin_e3",  32'(bs_a), 32'(6'b110_110));
                chk("upd_e3",      32'(upd_a), 32'(2'b11));
        tick(); chk("upd_e4",      32'(upd_a), 32'h0);

        in_a = 6'd0;
        sb_q.push_back(mk(1'b0, 3'b000, 3'b000, 1'b1, 3'd2));
        sb_q.push_back(mk(1'b1, 3'b000, 3'b000, 1'b1, 3'd2));
        repeat (4) tick();
        clr_a = 2'b11; tick(); clr_a = 2'b00;
        chk("err_clr_both", 32'(err_a), 32'h0);

        // Gray count on channel 0 including the 100 -> 000 wrap
        for (int i = 0; i < 8; i++) begin
            in_a[2:0] = gseq[i];
            sb_q.push_back(mk(1'b0, gseq[i], bseq[i], 1'b0, 3'd1));
            repeat (4) tick();
        end
        chk("wrap_no_err", 32'(err_a), 32'h0);

        in_a[2:0] = 3'b011;
        sb_q.push_back(mk(1'b0, 3'b011, 3'd2, 1'b1, 3'd2));
        repeat (4) tick();
        chk("viol_sticky", 32'(err_a), 32'(2'b01));
        clr_a = 2'b01; tick(); clr_a = 2'b00;
        chk("viol_clr", 32'(err_a), 32'h0);

        // Clear coincides with a new 3-bit violation: set wins
        in_a[2:0] = 3'b100;
        sb_q.push_back(mk(1'b0, 3'b100, 3'd7, 1'b1, 3'd5));
        tick(); tick();
        clr_a = 2'b01; tick(); clr_a = 2'b00;
        chk("set_beats_clr", 32'(err_a), 32'(2'b01));
        repeat (2) tick();

        in_a[5:3] = 3'b011;
        sb_q.push_back(mk(1'b1, 3'b011, 3'd2, 1'b1, 3'd2));
        repeat (4) tick();
        in_a[5:3] = 3'b111;
        sb_q.push_back(mk(1'b1, 3'b111, 3'd5, 1'b1, 3'd3));
        repeat (4) tick();

        // Mid-operation reset with 101 sitting in stage 0
        in_a[2:0] = 3'b101;
        tick();
        rst_a = 1'b0; in_a = 6'd0;
        #1;
        chk("midrst_gray", 32'(gs_a), 32'h0);
        chk("midrst_bin",  32'(bs_a), 32'h0);
        chk("midrst_err",  32'(err_a), 32'h0);
        tick(); rst_a = 1'b1;
        repeat (6) tick();
        chk("postrst_bin", 32'(bs_a), 32'h0);
        in_a[2:0] = 3'b001;
        sb_q.push_back(mk(1'b0, 3'b001, 3'd1, 1'b0, 3'd1));
        repeat (4) tick();

        // STAGES=4, NCH=3: bin values 1, 2, 4
        rst_b = 1'b1;
        tick();
        in_b = {3'b110, 3'b011, 3'b001};
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("b_gray_e%0d", k), 32'(gs_b), (k >= 4) ? 32'(9'b110_011_001) : 32'h0);
            chk($sformatf("b_bin_e%0d", k),  32'(bs_b), (k >= 5) ? 32'(9'b100_010_001) : 32'h0);
            chk($sformatf("b_upd_e%0d", k),  32'(upd_b), (k == 5) ? 32'(3'b111) : 32'h0);
        end
        chk("b_err", 32'(err_b), 32'(3'b110));
        in_b[5:3] = 3'b010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("b2_gray_e%0d", k), 32'(gs_b), (k >= 4) ? 32'(9'b110_010_001) : 32'(9'b110_011_001));
            chk($sformatf("b2_upd_e%0d", k),  32'(upd_b), (k == 5) ? 32'(3'b010) : 32'h0);
        end
        chk("b2_bin", 32'(bs_b), 32'(9'b100_011_001));

        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
